// File: rtl/spi_slave_tx_if.sv
// Bundle of the SPI pins and the fabric-side byte handshake of the SPI slave transmit path.
// The slave modport is the transmitter's view; master is the view of whoever drives SPI and offers bytes.
interface spi_slave_tx_if #(
  parameter int DATA_W = 8
);
  logic              i_spi_sclk;
  logic              i_spi_cs_n;
  logic              o_spi_miso;
  logic              o_spi_miso_oe;
  logic [DATA_W-1:0] i_tx_data;
  logic              i_tx_valid;
  logic              o_tx_ready;
  logic              o_tx_done;
  logic              o_tx_underrun;

  modport slave (
    input  i_spi_sclk, i_spi_cs_n, i_tx_data, i_tx_valid,
    output o_spi_miso, o_spi_miso_oe, o_tx_ready, o_tx_done, o_tx_underrun
  );

  modport master (
    output i_spi_sclk, i_spi_cs_n, i_tx_data, i_tx_valid,
    input  o_spi_miso, o_spi_miso_oe, o_tx_ready, o_tx_done, o_tx_underrun
  );
endinterface

// File: rtl/spi_slave_tx.sv
// SPI mode-0 slave transmitter (MISO, MSB first) with a one-entry holding buffer.
// SCLK/CS_N are oversampled in clk; every output is a flop.
module spi_slave_tx #(
  parameter int              DATA_W      = 8,
  parameter int              SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] IDLE_BYTE = 8'hA5
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_slave_tx_if.slave  bus
);

  localparam int              CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_r, cs_sync_r;
  logic                   sclk_hist_r, cs_hist_r;
  logic                   sclk_rise_s, sclk_fall_s, cs_rise_s, cs_fall_s;

  state_t            state_r, state_nxt_s;
  logic [DATA_W-1:0] shift_r, shift_nxt_s;
  logic [DATA_W-1:0] buf_r, buf_nxt_s;
  logic              buf_full_r, buf_full_nxt_s;
  logic [CNT_W-1:0]  bit_cnt_r, bit_cnt_nxt_s;
  logic              reload_pend_r, reload_pend_nxt_s;
  logic              miso_r, miso_nxt_s;
  logic              oe_r, oe_nxt_s;
  logic              ready_r;
  logic              done_r, done_nxt_s;
  logic              underrun_r, underrun_nxt_s;
  logic              load_s;

  // Synchroniser and edge-history flops. CS_N resets low so that a CS held low
  // across reset release never looks like a fresh select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_r <= '0;
      cs_sync_r   <= '0;
      sclk_hist_r <= 1'b0;
      cs_hist_r   <= 1'b0;
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], bus.i_spi_sclk};
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], bus.i_spi_cs_n};
      sclk_hist_r <= sclk_sync_r[SYNC_STAGES-1];
      cs_hist_r   <= cs_sync_r[SYNC_STAGES-1];
    end
  end

  assign sclk_rise_s = sclk_sync_r[SYNC_STAGES-1] & ~sclk_hist_r;
  assign sclk_fall_s = ~sclk_sync_r[SYNC_STAGES-1] & sclk_hist_r;
  assign cs_rise_s   = cs_sync_r[SYNC_STAGES-1] & ~cs_hist_r;
  assign cs_fall_s   = ~cs_sync_r[SYNC_STAGES-1] & cs_hist_r;

  // Next-state, shift/reload datapath and holding-buffer control.
  always_comb begin
    state_nxt_s       = state_r;
    shift_nxt_s       = shift_r;
    buf_nxt_s         = buf_r;
    buf_full_nxt_s    = buf_full_r;
    bit_cnt_nxt_s     = bit_cnt_r;
    reload_pend_nxt_s = reload_pend_r;
    miso_nxt_s        = miso_r;
    oe_nxt_s          = oe_r;
    done_nxt_s        = 1'b0;
    underrun_nxt_s    = 1'b0;
    load_s            = 1'b0;

    case (state_r)
      ST_IDLE: begin
        oe_nxt_s          = 1'b0;
        miso_nxt_s        = 1'b0;
        bit_cnt_nxt_s     = '0;
        reload_pend_nxt_s = 1'b0;
        if (cs_fall_s) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (cs_rise_s) begin
          state_nxt_s   = ST_IDLE;
          oe_nxt_s      = 1'b0;
          miso_nxt_s    = 1'b0;
          bit_cnt_nxt_s = '0;
        end else begin
          load_s            = 1'b1;
          oe_nxt_s          = 1'b1;
          bit_cnt_nxt_s     = '0;
          reload_pend_nxt_s = 1'b0;
          state_nxt_s       = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Deselect wins over any SCLK edge seen in the same cycle.
        if (cs_rise_s) begin
          state_nxt_s       = ST_IDLE;
          oe_nxt_s          = 1'b0;
          miso_nxt_s        = 1'b0;
          bit_cnt_nxt_s     = '0;
          reload_pend_nxt_s = 1'b0;
        end else if (sclk_rise_s) begin
          if (bit_cnt_r == LAST_BIT) begin
            bit_cnt_nxt_s     = '0;
            done_nxt_s        = 1'b1;
            reload_pend_nxt_s = 1'b1;
          end else begin
            bit_cnt_nxt_s = bit_cnt_r + CNT_W'(1);
          end
        end else if (sclk_fall_s) begin
          if (reload_pend_r) begin
            load_s            = 1'b1;
            reload_pend_nxt_s = 1'b0;
          end else begin
            shift_nxt_s = {shift_r[DATA_W-2:0], 1'b0};
            miso_nxt_s  = shift_r[DATA_W-2];
          end
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        oe_nxt_s    = 1'b0;
        miso_nxt_s  = 1'b0;
      end
    endcase

    // Word source priority: buffered byte, then same-cycle bypass, then the idle filler.
    if (load_s) begin
      if (buf_full_r) begin
        shift_nxt_s    = buf_r;
        buf_full_nxt_s = 1'b0;
      end else if (bus.i_tx_valid) begin
        shift_nxt_s = bus.i_tx_data;
      end else begin
        shift_nxt_s    = IDLE_BYTE;
        underrun_nxt_s = 1'b1;
      end
      miso_nxt_s = shift_nxt_s[DATA_W-1];
    end else begin
      load_s = 1'b0;
    end

    if (bus.i_tx_valid && ready_r && !load_s) begin
      buf_nxt_s      = bus.i_tx_data;
      buf_full_nxt_s = 1'b1;
    end else begin
      buf_nxt_s = buf_nxt_s;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      shift_r       <= '0;
      buf_r         <= '0;
      buf_full_r    <= 1'b0;
      bit_cnt_r     <= '0;
      reload_pend_r <= 1'b0;
      miso_r        <= 1'b0;
      oe_r          <= 1'b0;
      ready_r       <= 1'b1;
      done_r        <= 1'b0;
      underrun_r    <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      shift_r       <= shift_nxt_s;
      buf_r         <= buf_nxt_s;
      buf_full_r    <= buf_full_nxt_s;
      bit_cnt_r     <= bit_cnt_nxt_s;
      reload_pend_r <= reload_pend_nxt_s;
      miso_r        <= miso_nxt_s;
      oe_r          <= oe_nxt_s;
      ready_r       <= ~buf_full_nxt_s;
      done_r        <= done_nxt_s;
      underrun_r    <= underrun_nxt_s;
    end
  end

  assign bus.o_spi_miso    = miso_r;
  assign bus.o_spi_miso_oe = oe_r;
  assign bus.o_tx_ready    = ready_r;
  assign bus.o_tx_done     = done_r;
  assign bus.o_tx_underrun = underrun_r;

endmodule
